// File: rtl/axi4lite_reg_ctrl.sv
// AXI4-Lite slave front-end for a bank of byte-strobed registers.
// Independent write (AW/W -> one-cycle strobe pulse -> B) and read (AR -> R) engines.
module axi4lite_reg_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS   = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS-1:0]            reg_wen,
  output logic [DATA_WIDTH/8-1:0]        reg_wstrb,
  output logic [DATA_WIDTH-1:0]          reg_wdata,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_rdata
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFFS   = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - OFFS;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_EXEC = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic       {R_IDLE = 1'b0, R_RESP = 1'b1} r_state_e;

  // One-hot register select; an out-of-range index yields all zeros.
  function automatic logic [NUM_REGS-1:0] decode(input logic [IDX_W-1:0] idx);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      oh[k] = (idx == IDX_W'(k));
    end
    return oh;
  endfunction

  w_state_e              w_state_q;
  r_state_e              r_state_q;
  logic                  aw_held_q, w_held_q;
  logic [IDX_W-1:0]      awidx_q;
  logic                  awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q, reg_wdata_q;
  logic [STRB_W-1:0]     reg_wstrb_q;
  logic [NUM_REGS-1:0]   reg_wen_q;

  logic                  aw_hs_s, w_hs_s, aw_held_d, w_held_d;
  logic [IDX_W-1:0]      awidx_d;
  logic [NUM_REGS-1:0]   rd_sel_s;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic                  addr_lsb_unused_s;

  // Byte-offset bits carry no meaning for word-indexed registers.
  assign addr_lsb_unused_s = ^{s_axi_awaddr[OFFS-1:0], s_axi_araddr[OFFS-1:0]};

  // Write-side handshakes and the address as it will be held after this edge.
  always_comb begin
    aw_hs_s   = s_axi_awvalid & awready_q;
    w_hs_s    = s_axi_wvalid & wready_q;
    aw_held_d = aw_held_q | aw_hs_s;
    w_held_d  = w_held_q | w_hs_s;
    if (aw_hs_s) begin
      awidx_d = s_axi_awaddr[ADDR_WIDTH-1:OFFS];
    end else begin
      awidx_d = awidx_q;
    end
  end

  // Read mux over the flattened bank, OR-reduced so misses return zero.
  always_comb begin
    rd_sel_s  = decode(s_axi_araddr[ADDR_WIDTH-1:OFFS]);
    rd_data_s = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      rd_data_s = rd_data_s | ({DATA_WIDTH{rd_sel_s[k]}} & reg_rdata[k*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Write FSM with registered readys, strobe pulse and response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state_q   <= W_IDLE;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      awidx_q     <= '0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      reg_wen_q   <= '0;
      reg_wstrb_q <= '0;
      reg_wdata_q <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          aw_held_q <= aw_held_d;
          w_held_q  <= w_held_d;
          awidx_q   <= awidx_d;
          if (w_hs_s) begin
            reg_wdata_q <= s_axi_wdata;
            reg_wstrb_q <= s_axi_wstrb;
          end
          if (aw_held_d && w_held_d) begin
            w_state_q <= W_EXEC;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            reg_wen_q <= decode(awidx_d);
          end else begin
            awready_q <= !aw_held_d;
            wready_q  <= !w_held_d;
          end
        end
        W_EXEC: begin
          w_state_q <= W_RESP;
          reg_wen_q <= '0;
          bvalid_q  <= 1'b1;
          bresp_q   <= (|decode(awidx_q)) ? RESP_OKAY : RESP_SLVERR;
        end
        W_RESP: begin
          if (s_axi_bready) begin
            w_state_q <= W_IDLE;
            bvalid_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: begin
          w_state_q <= W_IDLE;
          aw_held_q <= 1'b0;
          w_held_q  <= 1'b0;
          awready_q <= 1'b0;
          wready_q  <= 1'b0;
          bvalid_q  <= 1'b0;
          reg_wen_q <= '0;
        end
      endcase
    end
  end

  // Read FSM: capture the addressed slice at AR, hold until R handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (s_axi_arvalid && arready_q) begin
            r_state_q <= R_RESP;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_data_s;
            rresp_q   <= (|rd_sel_s) ? RESP_OKAY : RESP_SLVERR;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_RESP: begin
          if (s_axi_rready) begin
            r_state_q <= R_IDLE;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
        default: begin
          r_state_q <= R_IDLE;
          arready_q <= 1'b0;
          rvalid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign reg_wen       = reg_wen_q;
  assign reg_wstrb     = reg_wstrb_q;
  assign reg_wdata     = reg_wdata_q;

endmodule

// File: tb/tb_axi4lite_reg_ctrl.sv
// Scoreboard bench for axi4lite_reg_ctrl: directed scenarios plus randomized traffic
// checked against an array model of the register bank.
module tb_axi4lite_reg_ctrl;
  localparam int NREG = 16;
  localparam int TMO  = 50;

  logic        clk, rst_n;
  logic [7:0]  s_axi_awaddr, s_axi_araddr;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata, s_axi_rdata;
  logic [3:0]  s_axi_wstrb, reg_wstrb;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready;
  logic [15:0] reg_wen;
  logic [31:0] reg_wdata;
  logic [NREG*32-1:0] reg_rdata;

  axi4lite_reg_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(NREG)) dut (
    .clk(clk), .reset(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .reg_wen(reg_wen),
    .reg_wstrb(reg_wstrb), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [15:0] wen; logic [3:0] strb; logic [31:0] data; } wen_t;
  wen_t        wen_q[$];
  logic [1:0]  b_q[$];
  logic [33:0] r_q[$];
  logic [31:0] mem [NREG];
  logic [31:0] bank [NREG];
  logic        bank_clr;
  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Register bank the controller drives.
  always @(posedge clk) begin
    for (int k = 0; k < NREG; k++) begin
      if (bank_clr) bank[k] <= 32'h0;
      else if (reg_wen[k]) bank[k] <= merge(bank[k], reg_wdata, reg_wstrb);
    end
  end

  always_comb begin
    reg_rdata = '0;
    for (int k = 0; k < NREG; k++) reg_rdata[k*32 +: 32] = bank[k];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  // Monitors: pop the scoreboard whenever the DUT presents a strobe or response.
  always @(negedge clk) begin
    if (rst_n && reg_wen != 16'h0) begin
      if (wen_q.size() == 0) begin
        check("wen_unexpected", {12'h0, reg_wen, reg_wstrb, reg_wdata}, 64'h0);
      end else begin
        wen_t e;
        e = wen_q.pop_front();
        check("wen_data", {12'h0, reg_wen, reg_wstrb, reg_wdata}, {12'h0, e.wen, e.strb, e.data});
      end
    end
    if (rst_n && s_axi_bvalid && s_axi_bready) begin
      if (b_q.size() == 0) check("b_unexpected", {63'h0, s_axi_bvalid}, 64'h0);
      else check("bresp", {62'h0, s_axi_bresp}, {62'h0, b_q.pop_front()});
    end
    if (rst_n && s_axi_rvalid && s_axi_rready) begin
      if (r_q.size() == 0) check("r_unexpected", {63'h0, s_axi_rvalid}, 64'h0);
      else check("rresp_rdata", {30'h0, s_axi_rresp, s_axi_rdata}, {30'h0, r_q.pop_front()});
    end
  end

  task automatic send_aw(input logic [7:0] a);
    int n;
    n = 0;
    s_axi_awaddr = a; s_axi_awvalid = 1'b1;
    while (!s_axi_awready && n < TMO) begin @(posedge clk); #1; n++; end
    if (n >= TMO) fail_now("aw_accept");
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
    while (!s_axi_wready && n < TMO) begin @(posedge clk); #1; n++; end
    if (n >= TMO) fail_now("w_accept");
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [7:0] a);
    int n;
    n = 0;
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    while (!s_axi_arready && n < TMO) begin @(posedge clk); #1; n++; end
    if (n >= TMO) fail_now("ar_accept");
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
  endtask

  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
  task automatic aw_w_pair(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead);
    fork
      begin
        if (lead < 0) repeat (-lead) begin @(posedge clk); #1; end
        send_w(d, s);
      end
      begin
        if (lead > 0) repeat (lead) begin @(posedge clk); #1; end
        send_aw(a);
      end
    join
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int lead, input int bdelay);
    int idx;
    logic inr;
    logic [1:0] er;
    logic [15:0] ewen;
    wen_t e;
    idx = int'(a) / 4;
    inr = (idx < NREG);
    er = inr ? 2'b00 : 2'b10;
    ewen = inr ? (16'h1 << idx) : 16'h0;
    e.wen = ewen; e.strb = s; e.data = d;
    if (inr) wen_q.push_back(e);
    b_q.push_back(er);
    s_axi_bready = 1'b0;
    aw_w_pair(a, d, s, lead);
    check("wen_pulse", {48'h0, reg_wen}, {48'h0, ewen});
    @(posedge clk); #1;
    check("b_latency", {47'h0, s_axi_bvalid, reg_wen}, {47'h0, 1'b1, 16'h0});
    if (bdelay > 0) begin
      s_axi_awaddr = 8'($urandom); s_axi_awvalid = 1'b1;
    end
    repeat (bdelay) begin
      check("b_stall", {60'h0, s_axi_bvalid, s_axi_bresp, s_axi_awready | s_axi_wready},
            {60'h0, 1'b1, er, 1'b0});
      @(posedge clk); #1;
    end
    s_axi_awvalid = 1'b0;
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    if (inr) mem[idx] = merge(mem[idx], d, s);
  endtask

  task automatic do_read(input logic [7:0] a, input int rdelay);
    int idx;
    logic [33:0] er;
    idx = int'(a) / 4;
    er = (idx < NREG) ? {2'b00, mem[idx]} : {2'b10, 32'h0};
    r_q.push_back(er);
    s_axi_rready = 1'b0;
    send_ar(a);
    check("r_latency", {63'h0, s_axi_rvalid}, 64'h1);
    repeat (rdelay) begin
      @(posedge clk); #1;
      check("r_stall", {28'h0, s_axi_rvalid, s_axi_arready, s_axi_rresp, s_axi_rdata},
            {28'h0, 1'b1, 1'b0, er});
    end
    s_axi_rready = 1'b1;
    @(posedge clk); #1;
    s_axi_rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    logic [31:0] d;
    for (int k = 0; k < NREG; k++) mem[k] = 32'h0;
    rst_n = 1'b0; bank_clr = 1'b1;
    s_axi_awaddr = 8'h0; s_axi_awvalid = 1'b0; s_axi_wdata = 32'h0; s_axi_wstrb = 4'h0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = 8'h0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
          s_axi_arready, s_axi_rvalid, s_axi_rresp, reg_wen, reg_wstrb}, 64'h0);
    check("reset_data", {s_axi_rdata, reg_wdata}, 64'h0);
    rst_n = 1'b1; bank_clr = 1'b0;
    check("readys_before_edge", {61'h0, s_axi_awready, s_axi_wready, s_axi_arready}, 64'h0);
    @(posedge clk); #1;
    check("readys_after_edge", {61'h0, s_axi_awready, s_axi_wready, s_axi_arready}, 64'h7);

    // Same-cycle write then readback; then byte-strobed split write with W first.
    do_write(8'h08, 32'hDEADBEEF, 4'hF, 0, 0);
    do_read(8'h08, 0);
    do_write(8'h0C, 32'hDEADBEEF, 4'hF, -2, 0);
    do_write(8'h0C, 32'h11223344, 4'b0101, 3, 0);
    do_read(8'h0C, 0);
    // Out of range.
    do_write(8'h40, 32'hCAFEF00D, 4'hF, 0, 0);
    do_read(8'h40, 0);
    // Backpressure on both channels at once.
    fork
      do_write(8'h10, 32'hA5A5_0F0F, 4'hF, 0, 10);
      do_read(8'h08, 10);
    join
    // Read races a write to the same register, then reads the new value.
    fork
      do_read(8'h04, 0);
      do_write(8'h04, 32'h5, 4'hF, 0, 0);
    join
    do_read(8'h04, 0);

    // Reset while the write response is pending.
    wen_q.push_back('{wen: 16'h0020, strb: 4'hF, data: 32'h600D_D00D});
    s_axi_bready = 1'b0;
    aw_w_pair(8'h14, 32'h600D_D00D, 4'hF, 0);
    @(posedge clk); #1;
    check("bvalid_before_reset", {63'h0, s_axi_bvalid}, 64'h1);
    mem[5] = 32'h600D_D00D;
    rst_n = 1'b0;
    #1;
    check("reset_async", {60'h0, s_axi_bvalid, s_axi_awready, s_axi_wready, s_axi_arready}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("readys_after_rerelease", {61'h0, s_axi_awready, s_axi_wready, s_axi_arready}, 64'h7);
    s_axi_bready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("no_stale_b", {63'h0, s_axi_bvalid}, 64'h0);
    end
    s_axi_bready = 1'b0;
    do_read(8'h14, 0);

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      a = 8'($urandom_range(0, 8'h5F));
      d = $urandom;
      case ($urandom_range(0, 2))
        0: do_write(a, d, 4'($urandom), int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)));
        1: do_read(a, int'($urandom_range(0, 3)));
        default: fork
          do_read(a, int'($urandom_range(0, 2)));
          do_write(a, d, 4'($urandom), int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 2)));
        join
      endcase
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(wen_q.size() + b_q.size() + r_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
